// File: rtl/wb_unit.sv
// wb_unit: writeback stage -- source select with load alignment, result FIFO,
// back-pressurable register-file write port, commit pulse and retired-instruction counter.
module wb_unit #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 3,
  parameter int LOAD_IDX = 1,
  parameter int DEPTH    = 2,
  parameter int AW       = 5,
  localparam int SW = $clog2(NUM_SRC),
  localparam int OW = $clog2(XLEN / 8),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prev_valid,
  output logic                    this_ready,
  input  logic                    in_reg_wen,
  input  logic [AW-1:0]           in_rd,
  input  logic [SW-1:0]           in_sel,
  input  logic [NUM_SRC*XLEN-1:0] in_src,
  input  logic [1:0]              in_ld_size,
  input  logic                    in_ld_unsigned,
  input  logic [OW-1:0]           in_ld_off,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    rf_wen,
  output logic [AW-1:0]           rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  input  logic                    rf_wready,
  output logic                    commit_valid,
  output logic [XLEN-1:0]         commit_pc,
  output logic [63:0]             instret
);
  logic [XLEN-1:0] raw, sh, msk, msb, ld, wdata;
  logic [1:0]      sz;
  logic [6:0]      nb;
  logic            neg;
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_SRC; i++) raw = (in_sel == SW'(i)) ? in_src[i*XLEN +: XLEN] : raw;
    sh  = raw >> {in_ld_off, 3'b000};
    sz  = (XLEN == 32 && in_ld_size == 2'd3) ? 2'd2 : in_ld_size;
    nb  = 7'd8 << sz;
    msk = (int'(nb) >= XLEN) ? '1 : ~({XLEN{1'b1}} << nb);
    // msb isolates the sign bit of the selected load width
    msb = msk & ~(msk >> 1);
    neg = !in_ld_unsigned && |(sh & msb);
    ld  = neg ? (sh | ~msk) : (sh & msk);
    wdata = (in_sel == SW'(LOAD_IDX)) ? ld : raw;
  end
  logic            wen_q  [DEPTH];
  logic [AW-1:0]   rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [PW-1:0]   rptr_q, wptr_q;
  logic [PW:0]     cnt_q, cnt_d;
  logic [63:0]     instret_q, instret_d;
  logic            head_valid, push, pop;
  assign head_valid   = cnt_q != '0;
  assign this_ready   = cnt_q != (PW+1)'(DEPTH);
  assign push         = prev_valid & this_ready;
  assign pop          = head_valid & (!wen_q[rptr_q] | rf_wready);
  assign cnt_d        = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign instret_d    = instret_q + 64'(pop);
  assign rf_wen       = head_valid & wen_q[rptr_q];
  assign rf_waddr     = rd_q[rptr_q];
  assign rf_wdata     = data_q[rptr_q];
  assign commit_valid = pop;
  assign commit_pc    = pc_q[rptr_q];
  assign instret      = instret_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        wen_q[i]  <= 1'b0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      instret_q <= '0;
    end else begin
      if (push) begin
        wen_q[wptr_q]  <= in_reg_wen && (in_rd != '0);
        rd_q[wptr_q]   <= in_rd;
        data_q[wptr_q] <= wdata;
        pc_q[wptr_q]   <= in_pc;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_unit;
  localparam int XLEN = 32, NUM_SRC = 3, LOAD_IDX = 1, DEPTH = 2, AW = 5;
  logic clk = 1'b0, rst;
  logic prev_valid, this_ready, in_reg_wen, in_ld_unsigned, rf_wen, rf_wready, commit_valid;
  logic [AW-1:0] in_rd, rf_waddr;
  logic [1:0] in_sel, in_ld_size, in_ld_off;
  logic [NUM_SRC*XLEN-1:0] in_src;
  logic [XLEN-1:0] in_pc, rf_wdata, commit_pc;
  logic [63:0] instret;
  int checks = 0, passed = 0;
  typedef struct {logic wen; logic [4:0] rd; logic [31:0] data; logic [31:0] pc;} ent_t;
  always #5 clk = ~clk;
  wb_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .LOAD_IDX(LOAD_IDX), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .prev_valid(prev_valid), .this_ready(this_ready),
    .in_reg_wen(in_reg_wen), .in_rd(in_rd), .in_sel(in_sel), .in_src(in_src),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_ld_off(in_ld_off),
    .in_pc(in_pc), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_wready(rf_wready), .commit_valid(commit_valid), .commit_pc(commit_pc), .instret(instret));
  function automatic logic [31:0] ref_val(logic [95:0] src, logic [1:0] sel, logic [1:0] size,
                                          logic uns, logic [1:0] off);
    logic [31:0] r, s;
    if (sel >= 2'd3) return 32'h0;
    r = src[sel*32 +: 32];
    if (sel != 2'd1) return r;
    s = r >> (off * 8);
    if (size == 2'd0) return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    if (size == 2'd1) return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return s;
  endfunction
  task automatic set_in(input logic v, input logic wen, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [95:0] src, input logic [1:0] sz, input logic uns,
                        input logic [1:0] off, input logic [31:0] pc);
    prev_valid = v; in_reg_wen = wen; in_rd = rd; in_sel = sel; in_src = src;
    in_ld_size = sz; in_ld_unsigned = uns; in_ld_off = off; in_pc = pc;
  endtask
  task automatic idle();
    set_in(1'b0, 1'b0, 5'd0, 2'd0, 96'h0, 2'd0, 1'b0, 2'd0, 32'h0);
  endtask
  task automatic test_reset();
    idle(); rf_wready = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (this_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", this_ready); else passed++;
    checks++; if (rf_wen !== 1'b0) $display("FAIL reset_rf_wen got %b exp 0", rf_wen); else passed++;
    checks++; if (commit_valid !== 1'b0) $display("FAIL reset_commit got %b exp 0", commit_valid); else passed++;
    checks++; if (instret !== 64'd0) $display("FAIL reset_instret got %0d exp 0", instret); else passed++;
    checks++; if ({rf_waddr, rf_wdata, commit_pc} !== '0) $display("FAIL reset_head got %h/%h/%h exp 0", rf_waddr, rf_wdata, commit_pc); else passed++;
    rst = 1'b0;
  endtask
  task automatic test_alu_stream();
    rf_wready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) set_in(1'b1, 1'b1, 5'(i + 1), 2'd0, {64'h0, 32'(8'h11 * (i + 1))}, 2'd0, 1'b0, 2'd0, 32'h100 + 32'(4 * i));
      else idle();
      #1;
      checks++; if (this_ready !== 1'b1) $display("FAIL alu_ready[%0d] got %b exp 1", i, this_ready); else passed++;
      if (i >= 1 && i <= 3) begin
        checks++; if (rf_wen !== 1'b1 || commit_valid !== 1'b1) $display("FAIL alu_wen[%0d] got %b/%b exp 1/1", i, rf_wen, commit_valid); else passed++;
        checks++; if (rf_waddr !== 5'(i) || rf_wdata !== 32'(8'h11 * i)) $display("FAIL alu_data[%0d] got %0d/%h exp %0d/%h", i, rf_waddr, rf_wdata, i, 8'h11 * i); else passed++;
        checks++; if (commit_pc !== 32'h100 + 32'(4 * (i - 1))) $display("FAIL alu_pc[%0d] got %h", i, commit_pc); else passed++;
      end else begin
        checks++; if (rf_wen !== 1'b0) $display("FAIL alu_idle_wen[%0d] got %b exp 0", i, rf_wen); else passed++;
      end
    end
    checks++; if (instret !== 64'd3) $display("FAIL alu_instret got %0d exp 3", instret); else passed++;
  endtask
  task automatic test_load_align();
    logic [1:0] sz [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic       un [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] of [4] = '{2'd1, 2'd2, 2'd2, 2'd0};
    logic [31:0] ex [4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000080FF, 32'h80FF7F01};
    logic [95:0] src;
    logic [1:0] sel, s, o;
    logic u;
    logic [31:0] exp;
    rf_wready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 4) begin
        sel = 2'd1; src = {32'h0, 32'h80FF7F01, 32'h0}; s = sz[i]; u = un[i]; o = of[i]; exp = ex[i];
      end else begin
        sel = 2'($urandom_range(0, 3)); src = {$urandom, $urandom, $urandom};
        s = 2'($urandom); u = 1'($urandom); o = 2'($urandom);
        exp = ref_val(src, sel, s, u, o);
      end
      set_in(1'b1, 1'b1, 5'd5, sel, src, s, u, o, 32'h200);
      @(negedge clk);
      idle();
      #1;
      checks++; if (rf_wen !== 1'b1 || rf_wdata !== exp) $display("FAIL load[%0d] got %b/%h exp 1/%h", i, rf_wen, rf_wdata, exp); else passed++;
    end
    @(negedge clk);
  endtask
  task automatic test_backpressure();
    ent_t e [3];
    for (int k = 0; k < 3; k++) e[k] = '{1'b1, 5'(10 + k), $urandom, 32'h300 + 32'(4 * k)};
    rf_wready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      set_in(1'b1, 1'b1, e[k > 2 ? 2 : k].rd, 2'd0, {64'h0, e[k > 2 ? 2 : k].data}, 2'd0, 1'b0, 2'd0, e[k > 2 ? 2 : k].pc);
      #1;
      checks++; if (this_ready !== (k < 2)) $display("FAIL bp_ready[%0d] got %b exp %b", k, this_ready, k < 2); else passed++;
      checks++; if (commit_valid !== 1'b0) $display("FAIL bp_commit[%0d] got %b exp 0", k, commit_valid); else passed++;
      if (k > 0) begin
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== e[0].rd || rf_wdata !== e[0].data) $display("FAIL bp_head[%0d] got %b/%0d/%h exp 1/%0d/%h", k, rf_wen, rf_waddr, rf_wdata, e[0].rd, e[0].data); else passed++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      rf_wready = 1'b1;
      if (j == 2) idle();
      #1;
      checks++; if (this_ready !== (j != 0)) $display("FAIL drain_ready[%0d] got %b exp %b", j, this_ready, j != 0); else passed++;
      checks++; if (commit_valid !== 1'b1 || commit_pc !== e[j].pc) $display("FAIL drain_commit[%0d] got %b/%h exp 1/%h", j, commit_valid, commit_pc, e[j].pc); else passed++;
      checks++; if (rf_waddr !== e[j].rd || rf_wdata !== e[j].data) $display("FAIL drain_data[%0d] got %0d/%h exp %0d/%h", j, rf_waddr, rf_wdata, e[j].rd, e[j].data); else passed++;
    end
    @(negedge clk);
    #1;
    checks++; if (instret !== 64'd22) $display("FAIL drain_instret got %0d exp 22", instret); else passed++;
    checks++; if (rf_wen !== 1'b0) $display("FAIL drain_empty got %b exp 0", rf_wen); else passed++;
  endtask
  task automatic test_mixed();
    rf_wready = 1'b0;
    @(negedge clk);
    set_in(1'b1, 1'b0, 5'd7, 2'd0, 96'h1, 2'd0, 1'b0, 2'd0, 32'h400);
    @(negedge clk);
    set_in(1'b1, 1'b1, 5'd0, 2'd0, 96'h2, 2'd0, 1'b0, 2'd0, 32'h404);
    #1;
    checks++; if (rf_wen !== 1'b0 || commit_valid !== 1'b1 || commit_pc !== 32'h400) $display("FAIL mix_nowen got %b/%b/%h exp 0/1/400", rf_wen, commit_valid, commit_pc); else passed++;
    @(negedge clk);
    set_in(1'b1, 1'b1, 5'd9, 2'd0, 96'h3, 2'd0, 1'b0, 2'd0, 32'h408);
    #1;
    checks++; if (rf_wen !== 1'b0 || commit_valid !== 1'b1 || commit_pc !== 32'h404) $display("FAIL mix_x0 got %b/%b/%h exp 0/1/404", rf_wen, commit_valid, commit_pc); else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      #1;
      checks++; if (rf_wen !== 1'b1 || commit_valid !== 1'b0 || rf_waddr !== 5'd9) $display("FAIL mix_stall[%0d] got %b/%b/%0d exp 1/0/9", k, rf_wen, commit_valid, rf_waddr); else passed++;
      checks++; if (instret !== 64'd24) $display("FAIL mix_instret[%0d] got %0d exp 24", k, instret); else passed++;
    end
    rf_wready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (instret !== 64'd25 || rf_wen !== 1'b0) $display("FAIL mix_release got %0d/%b exp 25/0", instret, rf_wen); else passed++;
  endtask
  task automatic test_async_reset();
    rf_wready = 1'b0;
    @(negedge clk);
    set_in(1'b1, 1'b1, 5'd3, 2'd0, 96'h55, 2'd0, 1'b0, 2'd0, 32'h500);
    @(negedge clk);
    set_in(1'b1, 1'b1, 5'd4, 2'd0, 96'h66, 2'd0, 1'b0, 2'd0, 32'h504);
    @(negedge clk);
    idle();
    #1;
    checks++; if (this_ready !== 1'b0 || rf_wen !== 1'b1) $display("FAIL ar_full got %b/%b exp 0/1", this_ready, rf_wen); else passed++;
    #1 rst = 1'b1;
    #1;
    checks++; if (this_ready !== 1'b1 || rf_wen !== 1'b0 || commit_valid !== 1'b0) $display("FAIL ar_ctrl got %b/%b/%b exp 1/0/0", this_ready, rf_wen, commit_valid); else passed++;
    checks++; if (instret !== 64'd0 || {rf_waddr, rf_wdata, commit_pc} !== '0) $display("FAIL ar_data got %0d/%h/%h/%h exp 0", instret, rf_waddr, rf_wdata, commit_pc); else passed++;
    rf_wready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++; if (commit_valid !== 1'b0 || instret !== 64'd0) $display("FAIL ar_post[%0d] got %b/%0d exp 0/0", k, commit_valid, instret); else passed++;
    end
  endtask
  task automatic test_instret_wrap();
    @(negedge clk);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    set_in(1'b1, 1'b0, 5'd1, 2'd0, 96'h0, 2'd0, 1'b0, 2'd0, 32'h600);
    #1;
    checks++; if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_pre got %h exp all-ones", instret); else passed++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (commit_valid !== 1'b1) $display("FAIL wrap_commit got %b exp 1", commit_valid); else passed++;
    @(negedge clk);
    #1;
    checks++; if (instret !== 64'd0) $display("FAIL wrap_post got %h exp 0", instret); else passed++;
  endtask
  task automatic test_random();
    ent_t q[$];
    ent_t h;
    logic [63:0] icnt = 64'd0;
    logic [95:0] src;
    logic [1:0] sel, s, o;
    logic u, wen, pop;
    logic [4:0] rd;
    logic [31:0] pc;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rf_wready = ($urandom_range(0, 99) < 60);
      src = {$urandom, $urandom, $urandom};
      sel = 2'($urandom); s = 2'($urandom); u = 1'($urandom); o = 2'($urandom);
      wen = 1'($urandom); rd = 5'($urandom_range(0, 7)); pc = $urandom;
      set_in($urandom_range(0, 99) < 70, wen, rd, sel, src, s, u, o, pc);
      #1;
      pop = q.size() > 0 && (!q[0].wen || rf_wready);
      checks++; if (this_ready !== (q.size() != DEPTH)) $display("FAIL rnd_ready[%0d] got %b exp %b", c, this_ready, q.size() != DEPTH); else passed++;
      checks++; if (commit_valid !== pop) $display("FAIL rnd_commit[%0d] got %b exp %b", c, commit_valid, pop); else passed++;
      checks++; if (instret !== icnt) $display("FAIL rnd_instret[%0d] got %0d exp %0d", c, instret, icnt); else passed++;
      checks++; if (rf_wen !== (q.size() > 0 && q[0].wen)) $display("FAIL rnd_wen[%0d] got %b", c, rf_wen); else passed++;
      if (q.size() > 0) begin
        h = q[0];
        checks++; if (rf_waddr !== h.rd || rf_wdata !== h.data || commit_pc !== h.pc) $display("FAIL rnd_head[%0d] got %0d/%h/%h exp %0d/%h/%h", c, rf_waddr, rf_wdata, commit_pc, h.rd, h.data, h.pc); else passed++;
      end
      if (prev_valid && q.size() < DEPTH) q.push_back('{wen && rd != 0, rd, ref_val(src, sel, s, u, o), pc});
      if (pop) begin
        void'(q.pop_front());
        icnt++;
      end
    end
    @(negedge clk);
    idle();
  endtask
  initial begin
    test_reset();
    test_alu_stream();
    test_load_align();
    test_backpressure();
    test_mixed();
    test_async_reset();
    test_instret_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
